// File: rtl/ram_occupancy_monitor.sv
// Per-channel event-RAM occupancy tracker with windowed maxima, hold snapshot and slow-control readout.
// Optional over-threshold cycle counters are built when OCC_OVERFLOW_CNT_EN is defined.
module ram_occupancy_monitor #(
    parameter int                N_CH   = 4,
    parameter int                CNT_W  = 16,
    parameter logic [CNT_W-1:0]  THRESH = 16'd1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    live,
    input  logic [N_CH*CNT_W-1:0]   n_write,
    input  logic [N_CH*CNT_W-1:0]   n_read,
    input  logic                    rd_req,
    input  logic [3:0]              rd_ch,
    output logic                    rd_valid,
    output logic [CNT_W-1:0]        rd_max,
    output logic [15:0]             rd_ovf,
    output logic                    rd_err,
    output logic [31:0]             live_len,
    output logic                    snap_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t             state_q;
    logic               live_d_q;
    logic [31:0]        len_q;
    logic [31:0]        live_len_q;
    logic               snap_q;

    logic [CNT_W-1:0]   occ_q      [N_CH];
    logic [CNT_W-1:0]   max_q      [N_CH];
    logic [CNT_W-1:0]   hold_max_q [N_CH];

    logic               rd_valid_q;
    logic [CNT_W-1:0]   rd_max_q;
    logic               rd_err_q;

    logic               rise;
    logic               fall;
    logic               start_w;
    logic               stop_w;
    logic               run_w;

    assign rise    = live & ~live_d_q;
    assign fall    = ~live & live_d_q;
    assign run_w   = (state_q == RUN);
    // A rise can only be seen outside RUN, a fall only inside it; qualifying keeps that explicit.
    assign start_w = rise & ~run_w;
    assign stop_w  = fall & run_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            live_d_q   <= 1'b0;
            len_q      <= 32'd0;
            live_len_q <= 32'd0;
            snap_q     <= 1'b0;
        end else begin
            live_d_q <= live;
            case (state_q)
                IDLE: begin
                    if (start_w) begin
                        state_q <= RUN;
                        len_q   <= 32'd1;
                    end
                end
                RUN: begin
                    if (stop_w) begin
                        state_q    <= HOLD;
                        live_len_q <= len_q;
                        snap_q     <= 1'b1;
                    end else begin
                        len_q <= sat_inc32(len_q);
                    end
                end
                HOLD: begin
                    if (start_w) begin
                        state_q <= RUN;
                        len_q   <= 32'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Stage 1 occupancy, stage 2 running maximum, snapshot on fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_CH; k++) begin
                occ_q[k]      <= '0;
                max_q[k]      <= '0;
                hold_max_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                occ_q[k] <= n_write[k*CNT_W +: CNT_W] - n_read[k*CNT_W +: CNT_W];
                if (start_w) begin
                    max_q[k] <= occ_q[k];
                end else if (run_w && (occ_q[k] > max_q[k])) begin
                    max_q[k] <= occ_q[k];
                end
                if (stop_w) begin
                    hold_max_q[k] <= max_q[k];
                end
            end
        end
    end

`ifdef OCC_OVERFLOW_CNT_EN
    logic [15:0] ovf_q      [N_CH];
    logic [15:0] hold_ovf_q [N_CH];
    logic [15:0] sel_ovf;
    logic [15:0] rd_ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_CH; k++) begin
                ovf_q[k]      <= 16'd0;
                hold_ovf_q[k] <= 16'd0;
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (start_w) begin
                    ovf_q[k] <= 16'd0;
                end else if (run_w && (occ_q[k] > THRESH)) begin
                    ovf_q[k] <= sat_inc16(ovf_q[k]);
                end
                if (stop_w) begin
                    hold_ovf_q[k] <= ovf_q[k];
                end
            end
        end
    end

    always_comb begin
        sel_ovf = 16'd0;
        for (int k = 0; k < N_CH; k++) begin
            if (rd_ch == 4'(k)) begin
                sel_ovf = hold_ovf_q[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ovf_q <= 16'd0;
        end else if (rd_req) begin
            rd_ovf_q <= sel_ovf;
        end
    end

    assign rd_ovf = rd_ovf_q;
`else
    logic unused_thresh;
    assign unused_thresh = ^THRESH;
    assign rd_ovf        = 16'h0000;
`endif

    logic [CNT_W-1:0] sel_max;
    logic             sel_err;

    // Out-of-range channels fall through the loop untouched, leaving data 0 and err set.
    always_comb begin
        sel_max = '0;
        sel_err = 1'b1;
        for (int k = 0; k < N_CH; k++) begin
            if (rd_ch == 4'(k)) begin
                sel_max = hold_max_q[k];
                sel_err = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_max_q   <= '0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= rd_req;
            if (rd_req) begin
                rd_max_q <= sel_max;
                rd_err_q <= sel_err;
            end
        end
    end

    assign rd_valid   = rd_valid_q;
    assign rd_max     = rd_max_q;
    assign rd_err     = rd_err_q;
    assign live_len   = live_len_q;
    assign snap_valid = snap_q;

endmodule

// File: tb/tb_ram_occupancy_monitor.sv
// Randomised and directed bench for ram_occupancy_monitor against a window-level behavioural model.
// Expected over-threshold counts follow OCC_OVERFLOW_CNT_EN the same way the design build does.
module tb_ram_occupancy_monitor;

    localparam int               N_CH   = 4;
    localparam int               CNT_W  = 16;
    localparam logic [15:0]      THRESH = 16'd1024;

    logic                   clk;
    logic                   rst_n;
    logic                   live;
    logic [N_CH*CNT_W-1:0]  n_write;
    logic [N_CH*CNT_W-1:0]  n_read;
    logic                   rd_req;
    logic [3:0]             rd_ch;
    logic                   rd_valid;
    logic [CNT_W-1:0]       rd_max;
    logic [15:0]            rd_ovf;
    logic                   rd_err;
    logic [31:0]            live_len;
    logic                   snap_valid;

    ram_occupancy_monitor #(.N_CH(N_CH), .CNT_W(CNT_W), .THRESH(THRESH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .live       (live),
        .n_write    (n_write),
        .n_read     (n_read),
        .rd_req     (rd_req),
        .rd_ch      (rd_ch),
        .rd_valid   (rd_valid),
        .rd_max     (rd_max),
        .rd_ovf     (rd_ovf),
        .rd_err     (rd_err),
        .live_len   (live_len),
        .snap_valid (snap_valid)
    );

    always #5 clk = ~clk;

    logic [15:0] wr_a [N_CH];
    logic [15:0] rp_a [N_CH];

    always_comb begin
        n_write = '0;
        n_read  = '0;
        for (int k = 0; k < N_CH; k++) begin
            n_write[k*CNT_W +: CNT_W] = wr_a[k];
            n_read[k*CNT_W +: CNT_W]  = rp_a[k];
        end
    end

    int n_checks;
    int n_errors;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Window-level model: a window spans the cycles live is high; because the occupancy is
    // registered before it is compared, the maximum covers the occupancies presented from the
    // cycle before the rise up to two cycles before the fall, and the over-threshold count
    // covers those presented from the rise cycle up to two cycles before the fall.
    logic [15:0] m_prev_occ [N_CH];
    logic        m_prev_live;
    int          m_len;
    logic [15:0] m_max [N_CH];
    int          m_ovf [N_CH];
    logic [15:0] h_max [N_CH];
    int          h_ovf [N_CH];
    int          h_len;
    logic        h_snap;

    task automatic model_reset();
        m_prev_live = 1'b0;
        m_len       = 0;
        h_len       = 0;
        h_snap      = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            m_prev_occ[k] = 16'd0;
            m_max[k]      = 16'd0;
            m_ovf[k]      = 0;
            h_max[k]      = 16'd0;
            h_ovf[k]      = 0;
        end
    endtask

    task automatic set_occ(input int k, input logic [15:0] v);
        rp_a[k] = 16'($urandom);
        wr_a[k] = rp_a[k] + v;
    endtask

    // Present the current inputs for one clock, advance the model, then check outputs.
    task automatic tick();
        logic        p_req;
        logic [15:0] e_max;
        int          e_ovf;
        logic        e_err;
        logic [15:0] occ_now [N_CH];
        p_req = rd_req;
        e_max = 16'd0;
        e_ovf = 0;
        e_err = 1'b1;
        if (int'(rd_ch) < N_CH) begin
            e_max = h_max[rd_ch];
            e_ovf = h_ovf[rd_ch];
            e_err = 1'b0;
        end
`ifndef OCC_OVERFLOW_CNT_EN
        e_ovf = 0;
`endif
        for (int k = 0; k < N_CH; k++) occ_now[k] = wr_a[k] - rp_a[k];
        if (live) begin
            if (!m_prev_live) begin
                m_len = 0;
                for (int k = 0; k < N_CH; k++) begin
                    m_max[k] = m_prev_occ[k];
                    m_ovf[k] = 0;
                end
            end else begin
                for (int k = 0; k < N_CH; k++) begin
                    if (m_prev_occ[k] > m_max[k]) m_max[k] = m_prev_occ[k];
                    if (m_prev_occ[k] > THRESH && m_ovf[k] < 65535) m_ovf[k]++;
                end
            end
            m_len++;
        end else if (m_prev_live) begin
            for (int k = 0; k < N_CH; k++) begin
                h_max[k] = m_max[k];
                h_ovf[k] = m_ovf[k];
            end
            h_len  = m_len;
            h_snap = 1'b1;
        end
        m_prev_live = live;
        for (int k = 0; k < N_CH; k++) m_prev_occ[k] = occ_now[k];
        @(posedge clk);
        #1;
        check_val("rd_valid", 32'(rd_valid), 32'(p_req));
        if (p_req) begin
            check_val("rd_max", 32'(rd_max), 32'(e_max));
            check_val("rd_ovf", 32'(rd_ovf), 32'(e_ovf));
            check_val("rd_err", 32'(rd_err), 32'(e_err));
        end
        check_val("snap_valid", 32'(snap_valid), 32'(h_snap));
        check_val("live_len", live_len, 32'(h_len));
        rd_req = 1'b0;
    endtask

    task automatic read_ch(input logic [3:0] ch);
        rd_req = 1'b1;
        rd_ch  = ch;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        check_val({tag, "_rd_max"}, 32'(rd_max), 32'd0);
        check_val({tag, "_rd_ovf"}, 32'(rd_ovf), 32'd0);
        check_val({tag, "_rd_err"}, 32'(rd_err), 32'd0);
        check_val({tag, "_live_len"}, live_len, 32'd0);
        check_val({tag, "_snap"}, 32'(snap_valid), 32'd0);
    endtask

    task automatic all_occ(input logic [15:0] v);
        for (int k = 0; k < N_CH; k++) set_occ(k, v);
    endtask

    initial begin
        clk      = 1'b0;
        rst_n    = 1'b0;
        live     = 1'b0;
        rd_req   = 1'b0;
        rd_ch    = 4'd0;
        n_checks = 0;
        n_errors = 0;
        for (int k = 0; k < N_CH; k++) begin
            wr_a[k] = 16'd0;
            rp_a[k] = 16'd0;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Reset readout.
        read_ch(4'd0);
        tick();

        // Basic window on ch2 with a 0 -> 37 -> 5 ramp.
        all_occ(16'd0);
        tick();
        live = 1'b1;
        tick();
        set_occ(2, 16'd37);
        repeat (3) tick();
        set_occ(2, 16'd5);
        repeat (3) tick();
        live = 1'b0;
        tick();
        tick();
        for (int c = 0; c < N_CH; c++) read_ch(4'(c));
        check_val("basic_len", live_len, 32'd7);

        // Pointer wrap on ch1.
        all_occ(16'd0);
        tick();
        wr_a[1] = 16'h0003;
        rp_a[1] = 16'hFFFE;
        tick();
        live = 1'b1;
        repeat (4) tick();
        live = 1'b0;
        repeat (2) tick();
        read_ch(4'd1);
        check_val("wrap_max", 32'(rd_max), 32'd5);

        // Threshold window, then reads between windows, then a lower second window.
        all_occ(16'd0);
        tick();
        live = 1'b1;
        set_occ(0, 16'd1025);
        repeat (10) tick();
        set_occ(0, 16'd1024);
        repeat (5) tick();
        live = 1'b0;
        set_occ(0, 16'd0);
        repeat (2) tick();
        read_ch(4'd0);
`ifdef OCC_OVERFLOW_CNT_EN
        check_val("thresh_ovf", 32'(rd_ovf), 32'd10);
`else
        check_val("thresh_ovf", 32'(rd_ovf), 32'd0);
`endif
        read_ch(4'd0);
        live = 1'b1;
        set_occ(0, 16'd100);
        repeat (2) tick();
        read_ch(4'd0);
        check_val("overlap_max", 32'(rd_max), 32'd1025);
        repeat (3) tick();
        live = 1'b0;
        repeat (2) tick();
        read_ch(4'd0);
        check_val("second_max", 32'(rd_max), 32'd100);

        // Simultaneous clear and compare on ch1.
        set_occ(1, 16'd50);
        live = 1'b1;
        repeat (4) tick();
        live = 1'b0;
        set_occ(1, 16'd9);
        repeat (3) tick();
        live = 1'b1;
        repeat (4) tick();
        live = 1'b0;
        repeat (2) tick();
        read_ch(4'd1);
        check_val("clear_max", 32'(rd_max), 32'd9);

        // One-cycle live pulse, then an out-of-range channel.
        live = 1'b1;
        tick();
        live = 1'b0;
        tick();
        check_val("pulse_len", live_len, 32'd1);
        read_ch(4'(N_CH));
        check_val("oob_err", 32'(rd_err), 32'd1);
        check_val("oob_max", 32'(rd_max), 32'd0);

        // Randomised traffic with back-to-back reads.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) live = ~live;
            for (int k = 0; k < N_CH; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 1) == 0) set_occ(k, 16'($urandom_range(1000, 1050)));
                    else set_occ(k, 16'($urandom));
                end
            end
            rd_req = ($urandom_range(0, 1) == 1);
            rd_ch  = 4'($urandom_range(0, N_CH + 1));
            tick();
        end
        live = 1'b0;
        repeat (2) tick();

        // Asynchronous reset in the middle of a window.
        live = 1'b1;
        all_occ(16'd77);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        model_reset();
        live = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        read_ch(4'd3);
        tick();
        live = 1'b1;
        repeat (3) tick();
        live = 1'b0;
        repeat (2) tick();
        read_ch(4'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
